fb_swap_scheduler: RTL and testbench

FB_SWAP_SCHEDULER -- requirements
Module: fb_swap_scheduler

---
 rtl/fb_swap_scheduler.sv | 93 +++++++++
 tb/tb_fb_swap_scheduler.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fb_swap_scheduler.sv
// fb_swap_scheduler: queues CPU pixel writes into the back framebuffer, yielding to scan-out,
// and swaps front/back buffers on the first vblank rising edge after a requested swap has drained.
module fb_swap_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int FB_SIZE    = 4800,
    parameter int ADDR_W     = 13
) (
    input  logic              CLK_SYS,
    input  logic              RST,
    input  logic              WR_VALID,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [2:0]        WR_DATA,
    input  logic              WR_SWAP,
    output logic              WR_READY,
    input  logic              SCAN_REQ,
    input  logic              VBLANK,
    output logic              FB_WE,
    output logic [ADDR_W-1:0] FB_ADDR,
    output logic [2:0]        FB_DATA,
    output logic              WRITE_SEL,
    output logic              DISPLAY_SEL,
    output logic              SWAP_PENDING,
    output logic [7:0]        DROP_COUNT
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DRAIN, WAIT_VBLANK, SWAP} state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_mem_addr [FIFO_DEPTH];
    logic [2:0]        r_mem_data [FIFO_DEPTH];
    logic [PW-1:0]     r_rd_ptr, r_wr_ptr;
    logic [PW:0]       r_count;
    logic              r_vblank_d, r_write_sel;
    logic [7:0]        r_drop;
    logic              w_acc, w_push, w_pop;

    assign WR_READY     = (r_state == IDLE) && (r_count != (PW+1)'(FIFO_DEPTH));
    assign w_acc        = WR_VALID && WR_READY;
    assign w_push       = w_acc && (WR_ADDR < ADDR_W'(FB_SIZE));
    assign w_pop        = (r_count != '0) && !SCAN_REQ;
    assign WRITE_SEL    = r_write_sel;
    assign DISPLAY_SEL  = ~r_write_sel;
    assign SWAP_PENDING = r_state != IDLE;
    assign DROP_COUNT   = r_drop;

    always_ff @(posedge CLK_SYS) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= WR_ADDR;
            r_mem_data[r_wr_ptr] <= WR_DATA;
        end
    end

    always_ff @(posedge CLK_SYS) begin
        if (RST) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_state     <= IDLE;
            r_vblank_d  <= 1'b0;
            r_write_sel <= 1'b0;
            r_drop      <= '0;
            FB_WE       <= 1'b0;
            FB_ADDR     <= '0;
            FB_DATA     <= '0;
        end else begin
            r_state    <= w_next;
            r_vblank_d <= VBLANK;
            r_count    <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
            FB_WE      <= w_pop;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                FB_ADDR  <= r_mem_addr[r_rd_ptr];
                FB_DATA  <= r_mem_data[r_rd_ptr];
            end
            if (w_acc && !w_push && r_drop != 8'hFF) r_drop <= r_drop + 1'b1;
            if (r_state == SWAP) r_write_sel <= ~r_write_sel;
        end
    end

    // Drain also waits for the last registered strobe so the swap never races a pending write.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:        w_next = (w_acc && WR_SWAP) ? DRAIN : IDLE;
            DRAIN:       w_next = (r_count == '0 && !FB_WE) ? WAIT_VBLANK : DRAIN;
            WAIT_VBLANK: w_next = (VBLANK && !r_vblank_d) ? SWAP : WAIT_VBLANK;
            SWAP:        w_next = IDLE;
            default:     w_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fb_swap_scheduler.sv
// tb_fb_swap_scheduler: randomized stimulus checked every cycle against a queue-based model,
// plus directed scenarios with literal expectations.
module tb_fb_swap_scheduler;
    localparam int DEPTH = 4;
    localparam int FBS   = 4800;

    logic        CLK_SYS = 0, RST = 1, WR_VALID = 0, WR_SWAP = 0, SCAN_REQ = 0, VBLANK = 0;
    logic [12:0] WR_ADDR = 0;
    logic [2:0]  WR_DATA = 0;
    logic        WR_READY, FB_WE, WRITE_SEL, DISPLAY_SEL, SWAP_PENDING;
    logic [12:0] FB_ADDR;
    logic [2:0]  FB_DATA;
    logic [7:0]  DROP_COUNT;

    fb_swap_scheduler #(.FIFO_DEPTH(DEPTH), .FB_SIZE(FBS), .ADDR_W(13)) dut (
        .CLK_SYS(CLK_SYS), .RST(RST), .WR_VALID(WR_VALID), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .WR_SWAP(WR_SWAP), .WR_READY(WR_READY), .SCAN_REQ(SCAN_REQ), .VBLANK(VBLANK),
        .FB_WE(FB_WE), .FB_ADDR(FB_ADDR), .FB_DATA(FB_DATA), .WRITE_SEL(WRITE_SEL),
        .DISPLAY_SEL(DISPLAY_SEL), .SWAP_PENDING(SWAP_PENDING), .DROP_COUNT(DROP_COUNT)
    );

    always #5 CLK_SYS = ~CLK_SYS;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: queue of pending pixels plus swap-progress flags, updated once per edge.
    logic [15:0] q[$];
    logic [15:0] m_e;
    bit          m_on = 0, m_we, m_sel, m_pend, m_drained, m_swapping, m_vprev;
    bit          m_ready, m_pop, m_rise;
    logic [12:0] m_addr;
    logic [2:0]  m_data;
    int          m_drop, m_swaps = 0;

    always @(posedge CLK_SYS) begin
        if (RST) begin
            q.delete();
            m_we = 0; m_addr = 0; m_data = 0; m_sel = 0; m_drop = 0;
            m_pend = 0; m_drained = 0; m_swapping = 0; m_vprev = 0; m_on = 1;
        end else if (m_on) begin
            m_ready = !m_pend && q.size() < DEPTH;
            m_pop   = q.size() > 0 && !SCAN_REQ;
            m_rise  = VBLANK && !m_vprev;
            if (m_swapping) begin
                m_sel = !m_sel; m_pend = 0; m_swapping = 0; m_swaps++;
            end else if (m_pend && m_drained && m_rise) m_swapping = 1;
            else if (m_pend && !m_drained && q.size() == 0 && !m_we) m_drained = 1;
            if (m_pop) begin
                m_e = q.pop_front();
                m_addr = m_e[15:3];
                m_data = m_e[2:0];
            end
            m_we = m_pop;
            if (WR_VALID && m_ready) begin
                if (int'(WR_ADDR) < FBS) q.push_back({WR_ADDR, WR_DATA});
                else if (m_drop < 255) m_drop++;
                if (WR_SWAP) begin m_pend = 1; m_drained = 0; end
            end
            m_vprev = VBLANK;
        end
    end

    always @(negedge CLK_SYS) begin
        if (m_on) begin
            chk("wr_ready", WR_READY, 32'(!m_pend && q.size() < DEPTH));
            chk("fb_we", FB_WE, 32'(m_we));
            chk("fb_addr", FB_ADDR, 32'(m_addr));
            chk("fb_data", FB_DATA, 32'(m_data));
            chk("write_sel", WRITE_SEL, 32'(m_sel));
            chk("display_sel", DISPLAY_SEL, 32'(!m_sel));
            chk("swap_pending", SWAP_PENDING, 32'(m_pend));
            chk("drop_count", DROP_COUNT, 32'(m_drop));
        end
    end

    task automatic step();
        @(posedge CLK_SYS);
        #1;
    endtask

    task automatic do_reset();
        RST = 1; WR_VALID = 0; WR_SWAP = 0; SCAN_REQ = 0;
        step(); step();
        RST = 0;
    endtask

    task automatic wr(input int a, input int d, input bit s);
        int n = 0;
        WR_VALID = 1; WR_ADDR = 13'(a); WR_DATA = 3'(d); WR_SWAP = s;
        while (!WR_READY && n < 200) begin step(); n++; end
        if (n >= 200) chk("wr_timeout", 1, 0);
        step();
        WR_VALID = 0; WR_SWAP = 0;
    endtask

    initial begin
        do_reset();
        chk("rst_fb_we", FB_WE, 0);
        chk("rst_display_sel", DISPLAY_SEL, 1);
        chk("rst_ready", WR_READY, 1);

        // Single write latency
        wr(10, 5, 0);
        chk("lat_we_early", FB_WE, 0);
        step();
        chk("lat_we", FB_WE, 1);
        chk("lat_addr", FB_ADDR, 10);
        chk("lat_data", FB_DATA, 5);
        chk("lat_sel", WRITE_SEL, 0);
        step();

        // Scan-out stall fills the queue
        do_reset();
        SCAN_REQ = 1;
        for (int i = 0; i < 4; i++) wr(100 + i, i, 0);
        WR_VALID = 1; WR_ADDR = 104; WR_DATA = 4;
        step();
        chk("full_ready", WR_READY, 0);
        chk("stall_we", FB_WE, 0);
        SCAN_REQ = 0;
        step();
        chk("first_pop_we", FB_WE, 1);
        chk("first_pop_addr", FB_ADDR, 100);
        wr(104, 4, 0);
        repeat (6) step();

        // Out-of-range drops and saturation
        do_reset();
        wr(4800, 1, 0);
        wr(4799, 2, 0);
        step();
        chk("edge_we", FB_WE, 1);
        chk("edge_addr", FB_ADDR, 4799);
        chk("drop_one", DROP_COUNT, 1);
        step();
        for (int i = 0; i < 300; i++) wr(5000, 0, 0);
        chk("drop_sat", DROP_COUNT, 255);
        chk("drop_no_we", FB_WE, 0);

        // Swap waits for a fresh vblank rising edge
        do_reset();
        VBLANK = 1;
        wr(1, 1, 0); wr(2, 2, 0); wr(3, 3, 1);
        repeat (10) step();
        chk("sw_pending", SWAP_PENDING, 1);
        chk("sw_ready", WR_READY, 0);
        chk("sw_sel_hold", WRITE_SEL, 0);
        VBLANK = 0; step();
        VBLANK = 1; step();
        chk("sw_in_swap", WRITE_SEL, 0);
        step();
        chk("sw_sel", WRITE_SEL, 1);
        chk("sw_disp", DISPLAY_SEL, 0);
        chk("sw_ready_back", WR_READY, 1);

        // Reset with a pending swap and queued entries
        SCAN_REQ = 1;
        wr(7, 1, 0); wr(8, 2, 1);
        chk("pre_rst_pending", SWAP_PENDING, 1);
        RST = 1; SCAN_REQ = 0;
        step();
        RST = 0;
        chk("mid_rst_we", FB_WE, 0);
        chk("mid_rst_sel", WRITE_SEL, 0);
        chk("mid_rst_pending", SWAP_PENDING, 0);
        step();
        chk("mid_rst_empty", FB_WE, 0);

        // Randomized traffic
        VBLANK = 0;
        for (int c = 0; c < 5000; c++) begin
            WR_VALID = 1'($urandom_range(0, 1));
            WR_ADDR  = ($urandom_range(0, 15) == 0) ? 13'($urandom_range(4800, 8191))
                                                     : 13'($urandom_range(0, 4799));
            WR_DATA  = 3'($urandom);
            WR_SWAP  = ($urandom_range(0, 11) == 0);
            SCAN_REQ = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 15) == 0) VBLANK = !VBLANK;
            RST = ($urandom_range(0, 799) == 0);
            step();
        end
        RST = 0; WR_VALID = 0;
        step();
        chk("swaps_seen", 32'(m_swaps > 3), 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
